// File: rtl/seg7_capture.sv
// seg7_capture: receive end of a multiplexed 7-segment display bus.
// It samples SEG and DIG and rejects glitches with a stability counter.
// Each stable digit pattern is decoded back to BCD, and one full frame of
// NDIG digits is presented through a valid/ready handshake.
//
// Ports:
//   clk, rst     system clock; synchronous active-high reset
//   SEG[6:0]     segment lines {a..g}, a = bit 6
//   DIG[NDIG-1:0] one-hot digit enables, bit 0 = rightmost digit
//   BCD          decoded digits, digit i at [4i+3:4i]
//   BLANK, ERR   per-digit blank / undecodable flags
//   FRAME_VALID  output registers hold a complete frame
//   FRAME_READY  consumer accepts the frame
//   OVR          sticky: a completed frame was dropped while FRAME_VALID was high
//
// Build option: define SEG7_CAPTURE_ACTLOW_EN to invert SEG and DIG at the
// input. Use it for common-anode, active-low drivers.
module seg7_capture #(
  parameter int unsigned NDIG   = 4,
  parameter int unsigned STABLE = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        SEG,
  input  logic [NDIG-1:0]   DIG,
  output logic [4*NDIG-1:0] BCD,
  output logic [NDIG-1:0]   BLANK,
  output logic [NDIG-1:0]   ERR,
  output logic              FRAME_VALID,
  input  logic              FRAME_READY,
  output logic              OVR
);

  localparam int unsigned CW = 8;
  localparam int unsigned PW = NDIG + 7;
  localparam logic [CW-1:0] STABLE_C = CW'(STABLE);

  typedef enum logic [0:0] {COLLECT, PRESENT} state_t;

  logic [PW-1:0]   pin;
  logic [PW-1:0]   sync_q;
  logic [NDIG-1:0] dig;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            match, onehot, accept;
  logic [5:0]      entry;
  logic [5:0]      store_q [NDIG];
  logic [NDIG-1:0] seen_q, seen_d;
  logic            full, load, clr_seen, set_ovr;
  state_t          state_q, state_d;

  // Pin polarity: the decoder always works in active-high terms.
`ifdef SEG7_CAPTURE_ACTLOW_EN
  assign pin = ~{DIG, SEG};
`else
  assign pin = {DIG, SEG};
`endif

  // Segment pattern to {bcd, blank, err}.
  function automatic logic [5:0] decode(input logic [6:0] s);
    case (s)
      7'h7E:   decode = {4'd0, 2'b00};
      7'h30:   decode = {4'd1, 2'b00};
      7'h6D:   decode = {4'd2, 2'b00};
      7'h79:   decode = {4'd3, 2'b00};
      7'h33:   decode = {4'd4, 2'b00};
      7'h5B:   decode = {4'd5, 2'b00};
      7'h5F:   decode = {4'd6, 2'b00};
      7'h70:   decode = {4'd7, 2'b00};
      7'h7F:   decode = {4'd8, 2'b00};
      7'h7B:   decode = {4'd9, 2'b00};
      7'h00:   decode = {4'hF, 2'b10};
      default: decode = {4'hE, 2'b01};
    endcase
  endfunction

  // The value being sampled this edge is compared with the previous sample.
  // Deciding on it directly puts accept at edge STABLE-1 of the run.
  assign dig    = pin[PW-1:7];
  assign match  = (pin == sync_q);
  assign onehot = (dig != '0) && ((dig & (dig - NDIG'(1))) == '0);
  assign entry  = decode(pin[6:0]);

  // Stability counter: reload on change, saturate at STABLE.
  always_comb begin
    cnt_d = cnt_q;
    if (!match)                cnt_d = CW'(1);
    else if (cnt_q != STABLE_C) cnt_d = cnt_q + CW'(1);
  end

  // One event per stable run: reaching STABLE, not sitting at it.
  assign accept = (cnt_d == STABLE_C) && (!match || (cnt_q != STABLE_C)) && onehot;

  assign full = &seen_q;

  // A digit accepted on the frame-complete edge belongs to the next frame.
  assign seen_d = (clr_seen ? '0 : seen_q) | (accept ? dig : '0);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= COLLECT;
    else     state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (full) state_d = PRESENT;
      PRESENT: if (FRAME_READY && !full) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // FSM outputs: load a frame, drop a frame (overrun), or wait.
  always_comb begin
    load     = 1'b0;
    clr_seen = 1'b0;
    set_ovr  = 1'b0;
    case (state_q)
      COLLECT: begin
        if (full) begin
          load     = 1'b1;
          clr_seen = 1'b1;
        end
      end
      PRESENT: begin
        if (full) begin
          clr_seen = 1'b1;
          if (FRAME_READY) load    = 1'b1;
          else             set_ovr = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign FRAME_VALID = (state_q == PRESENT);

  // Input stage, working store and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      seen_q <= '0;
      for (int i = 0; i < NDIG; i++) store_q[i] <= '0;
      BCD    <= '1;
      BLANK  <= '1;
      ERR    <= '0;
      OVR    <= 1'b0;
    end else begin
      sync_q <= pin;
      cnt_q  <= cnt_d;
      seen_q <= seen_d;
      for (int i = 0; i < NDIG; i++) begin
        if (accept && dig[i]) store_q[i] <= entry;
      end
      if (load) begin
        for (int i = 0; i < NDIG; i++) begin
          BCD[4*i +: 4] <= store_q[i][5:2];
          BLANK[i]      <= store_q[i][1];
          ERR[i]        <= store_q[i][0];
        end
      end
      if (set_ovr) OVR <= 1'b1;
    end
  end

endmodule
